tdc_code_averager: RTL

- Sits directly downstream of the TDC popcount stage.
- Consumes the registered popcount code `y` (thermometer-to-binary delay estimate) with a valid qualifier.
- Accumulates a window of 2^LOG2_SAMPLES codes and reports sum, truncated mean and, optionally, min/max over a valid/ready output handshake.
- Gives software or a downstream readout stage a noise-reduced time measurement per window.

---
 rtl/tdc_pkg.sv | 23 ++
 rtl/tdc_minmax_tracker.sv | 40 ++++
 rtl/tdc_code_averager.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tdc_pkg
// Desc   : Shared types and helpers for the TDC code averager.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package tdc_pkg;

    localparam int TDC_AVG_MAX_LOG2 = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } tdc_avg_state_t;

    // Code width needed to hold 0..n inclusive.
    function automatic int tdc_code_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_minmax_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tdc_minmax_tracker
// Desc   : Running minimum/maximum of a stream of codes over one window.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tdc_minmax_tracker #(
    parameter int W    = 7,
    parameter int MAXV = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         update,
    input  logic [W-1:0] value,
    output logic [W-1:0] min_code,
    output logic [W-1:0] max_code
);

    localparam logic [W-1:0] C_MAXV = W'(MAXV);

    always_ff @(posedge clk) begin
        if (!rst) begin
            min_code <= '0;
            max_code <= '0;
        end else if (clear) begin
            min_code <= C_MAXV;
            max_code <= '0;
        end else if (update) begin
            if (value < min_code) begin
                min_code <= value;
            end
            if (value > max_code) begin
                max_code <= value;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdc_code_averager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tdc_code_averager
// Desc   : Windowed sum/mean (and optional min/max, TDC_AVG_MINMAX_EN) of
//          TDC popcount codes with a valid/ready result handshake.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tdc_code_averager
    import tdc_pkg::*;
#(
    parameter int N            = 64,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  in_valid,
    input  logic [tdc_code_w(N)-1:0]              in_code,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [tdc_code_w(N)+LOG2_SAMPLES-1:0] out_sum,
    output logic [tdc_code_w(N)-1:0]              out_mean,
    output logic [tdc_code_w(N)-1:0]              out_min,
    output logic [tdc_code_w(N)-1:0]              out_max,
    output logic                                  busy,
    output logic                                  overrun
);

    localparam int W  = tdc_code_w(N);
    localparam int SW = W + LOG2_SAMPLES;

    localparam logic [W-1:0]            C_NCODE    = W'(N);
    localparam logic [LOG2_SAMPLES-1:0] C_CNT_LAST = '1;
    localparam logic [LOG2_SAMPLES-1:0] C_CNT_ONE  = LOG2_SAMPLES'(1);

    generate
        if (LOG2_SAMPLES < 1 || LOG2_SAMPLES > TDC_AVG_MAX_LOG2) begin : g_bad_log2
            $error("LOG2_SAMPLES out of range 1..8");
        end
    endgenerate

    tdc_avg_state_t          r_state;
    logic [SW-1:0]           r_acc;
    logic [LOG2_SAMPLES-1:0] r_cnt;

    logic [W-1:0] w_clamped;
    logic         w_start_window;

    assign w_clamped = (in_code > C_NCODE) ? C_NCODE : in_code;

    // A new window opens from IDLE, or straight out of DONE on the accepting cycle.
    assign w_start_window = start &&
                            ((r_state == IDLE) ||
                             ((r_state == DONE) && out_ready));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ACCUM;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        overrun <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_acc <= r_acc + SW'(w_clamped);
                        r_cnt <= r_cnt + C_CNT_ONE;
                        if (r_cnt == C_CNT_LAST) begin
                            r_state   <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Samples arriving while the result is pending are lost.
                    if (in_valid && !w_start_window) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            r_state <= ACCUM;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                            overrun <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_sum  = r_acc;
    assign out_mean = r_acc[SW-1:LOG2_SAMPLES];

`ifdef TDC_AVG_MINMAX_EN
    logic w_update;
    assign w_update = (r_state == ACCUM) && in_valid;

    tdc_minmax_tracker #(
        .W    (W),
        .MAXV (N)
    ) u_minmax (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_start_window),
        .update   (w_update),
        .value    (w_clamped),
        .min_code (out_min),
        .max_code (out_max)
    );
`else
    assign out_min = '0;
    assign out_max = '0;
`endif

endmodule
`default_nettype wire
